palette_lookup: RTL
===================

// Module: palette_lookup
// PURPOSE
//  Downstream consumer of the palette RAM read port: converts the composer's 8-bit pixel-index stream into RGB444.
//  Drives rd_addr into the palette RAM and aligns RAM read data with the delayed sync/blank sideband.
//  Applies frame-synchronous brightness fading, then feeds the video output encoder (VGA/NTSC).
// PARAMETERS
//  RD_LATENCY        1  palette RAM read latency in clk_i cycles (legal: 1 or 2)
//  FADE_STEP_FRAMES  1  vsync rising edges per fade level step (legal: 1..255)
// PORTS
//  clk_i           in   1   pixel clock; also the palette RAM rd_clk_i
//  rst_ni          in   1   asynchronous active-low reset
//  pix_valid_i     in   1   pixel index valid this cycle
//  pix_idx_i       in   8   pixel palette index
//  border_i        in   1   use border_idx_i instead of pix_idx_i
//  border_idx_i    in   8   border colour index
//  hsync_i         in   1   horizontal sync, aligned with pix_valid_i
//  vsync_i         in   1   vertical sync, aligned with pix_valid_i
//  blank_i         in   1   blanking, aligned with pix_valid_i
//  pal_rd_en_o     out  1   palette RAM read enable
//  pal_rd_addr_o   out  8   palette RAM read address
//  pal_rd_data_i   in   16  palette RAM read data, {4'hx,R[3:0],G[3:0],B[3:0]}
//  rgb_o           out  12  {R,G,B} after fade and blanking
//  rgb_valid_o     out  1   rgb_o valid
//  hsync_o         out  1   delayed hsync
//  vsync_o         out  1   delayed vsync
//  blank_o         out  1   delayed blank
//  fade_start_i    in   1   one-cycle pulse: start a fade
//  fade_dir_i      in   1   0 = fade out (toward 0), 1 = fade in (toward 16)
//  fade_busy_o     out  1   fade in progress
//  fade_level_o    out  5   current brightness level 0..16
// BEHAVIOUR
//  - Reset: rgb_o=0, rgb_valid_o=0, hsync_o=vsync_o=0, blank_o=1, pal_rd_en_o=0, fade_busy_o=0, fade_level_o=16.
//    The sideband/valid delay line is cleared. Reset mid-fade aborts the fade and restores level 16.
//  - Address: pal_rd_addr_o = border_i ? border_idx_i : pix_idx_i (combinational).
//    pal_rd_en_o = pix_valid_i. The RAM registers the read.
//  - Latency: input cycle N -> rgb_o/rgb_valid_o/sideband registered at cycle N+RD_LATENCY+1. Fixed, no stalls.
//    Back-to-back pixels are accepted every cycle.
//  - Sideband: pix_valid, hsync, vsync and blank pass through an RD_LATENCY+1 deep shift register.
//    Sideband shifts every cycle, including cycles with pix_valid_i=0.
//  - Unpack: R=data[11:8], G=data[7:4], B=data[3:0]; bits [15:12] ignored.
//  - Scale per component: 9-bit product c*level, output bits [7:4].
//    Level 16 -> identity; level 0 -> 0; max product 240 (no overflow).
//  - Blanking: delayed blank=1 or delayed valid=0 -> rgb_o=12'h000.
//  - Fade FSM states: IDLE, FADE_OUT, FADE_IN.
//    - IDLE + fade_start_i with dir=0 and level>0 -> FADE_OUT. With dir=1 and level<16 -> FADE_IN.
//    - Start when already at the target level: remain in IDLE, fade_busy_o stays 0.
//    - Busy: a step counter counts vsync_i rising edges (edges on the input, not the delayed vsync).
//      Every FADE_STEP_FRAMES edges, level -/+1. Reaching 0 or 16 -> IDLE in the same cycle as the last step.
//    - fade_start_i while busy is ignored.
//    - A start coincident with a vsync edge does not count that edge. The first counted edge is strictly later.
//    - Level changes only at vsync edges, so no mid-frame tearing. fade_busy_o=1 exactly in FADE_OUT/FADE_IN.
// CONFIGURATION
//  PALETTE_LOOKUP_FADE_EN defined: fade FSM, step counter and multipliers present as above.
//  Not defined: level constant 16 and rgb_o = unpacked data. fade_busy_o=0, fade_level_o=16, fade_start_i/fade_dir_i ignored.
//    Latency is unchanged.
// STRUCTURE
//  Shared package palette_pkg:
//    - RGB444 field offsets
//    - FADE_LEVEL_MAX=16, FADE_LEVEL_W=5
//    - fade_state_t enum {IDLE, FADE_OUT, FADE_IN}
//  Sub-module palette_fade_ctrl: FSM, vsync edge detect, step counter; outputs level and busy.
//    Instantiated only under PALETTE_LOOKUP_FADE_EN.
//  Datapath (address mux, delay line, scale, blank) lives in palette_lookup.
// TESTING
//  1. RAM[0x12]=16'h0F80, stream idx 0x12 with valid, RD_LATENCY=1 -> rgb_o=12'hF80, rgb_valid_o exactly 2 cycles later.
//  2. border_i=1, border_idx_i=0x05, RAM[5]=16'h0123, pix_idx_i=0x12 -> pal_rd_addr_o=0x05, rgb_o=12'h123.
//  3. blank_i=1 on pixel with RAM data 16'h0FFF -> rgb_o=0, blank_o=1 aligned with the delayed pixel.
//  4. FADE_STEP_FRAMES=1, fade_start_i dir=0, 16 vsync pulses, then pixel 12'hFFF.
//     -> fade_level_o 16,15,..,0, busy drops on the 16th edge, output rgb 12'h000.
//     At level 8 the same pixel gives 12'h777.
//  5. fade_start_i dir=1 at level 16 -> fade_busy_o stays 0. A second start during FADE_OUT is ignored.
//  6. Assert rst_ni low mid-fade at level 7 -> fade_level_o=16, fade_busy_o=0, rgb_valid_o=0 immediately (async).

Source files
------------

// File: rtl/palette_pkg.sv
// Shared types and constants for the palette lookup datapath and its fade controller.
package palette_pkg;

  localparam int COMP_W       = 4;
  localparam int RGB_W        = 12;
  localparam int R_LSB        = 8;
  localparam int G_LSB        = 4;
  localparam int B_LSB        = 0;
  localparam int FADE_LEVEL_W = 5;

  localparam logic [FADE_LEVEL_W-1:0] FADE_LEVEL_MAX = 5'd16;

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    FADE_IN
  } fade_state_t;

  typedef struct packed {
    logic valid;
    logic hsync;
    logic vsync;
    logic blank;
  } sideband_t;

  localparam sideband_t SIDEBAND_RESET = '{valid: 1'b0, hsync: 1'b0, vsync: 1'b0, blank: 1'b1};

  // Brightness scale: level 16 is identity, level 0 is black; product never exceeds 240.
  function automatic logic [COMP_W-1:0] scale_comp(input logic [COMP_W-1:0]       c,
                                                   input logic [FADE_LEVEL_W-1:0] level);
    logic [8:0] prod;
    prod = 9'(c) * 9'(level);
    return prod[7:4];
  endfunction

endpackage

// File: rtl/palette_fade_ctrl.sv
// Frame-synchronous fade controller: steps the brightness level on input vsync rising edges.
module palette_fade_ctrl
  import palette_pkg::*;
#(
  parameter int STEP_FRAMES = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    vsync_i,
  input  logic                    start_i,
  input  logic                    dir_i,
  output logic [FADE_LEVEL_W-1:0] level_o,
  output logic                    busy_o
);

  localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES - 1);

  fade_state_t             state_q, state_d;
  logic [FADE_LEVEL_W-1:0] level_q, level_d;
  logic                    busy_q, busy_d;
  logic [7:0]              step_cnt_q, step_cnt_d;
  logic                    vsync_prev_q, vsync_prev_d;
  logic                    vsync_rise;

  // A start in the same cycle as an edge is taken while IDLE, so that edge is never counted.
  assign vsync_rise = vsync_i & ~vsync_prev_q;

  always_comb begin
    // NOTE: every _d signal gets its default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    level_d      = level_q;
    step_cnt_d   = step_cnt_q;
    vsync_prev_d = vsync_i;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          step_cnt_d = '0;
          if (!dir_i && level_q != '0) begin
            state_d = FADE_OUT;
          end else if (dir_i && level_q != FADE_LEVEL_MAX) begin
            state_d = FADE_IN;
          end
        end
      end
      FADE_OUT, FADE_IN: begin
        if (vsync_rise) begin
          if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = '0;
            if (state_q == FADE_OUT) begin
              level_d = level_q - FADE_LEVEL_W'(1);
              if (level_d == '0) state_d = IDLE;
            end else begin
              level_d = level_q + FADE_LEVEL_W'(1);
              if (level_d == FADE_LEVEL_MAX) state_d = IDLE;
            end
          end else begin
            step_cnt_d = step_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      level_q      <= FADE_LEVEL_MAX;
      busy_q       <= 1'b0;
      step_cnt_q   <= '0;
      vsync_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      busy_q       <= busy_d;
      step_cnt_q   <= step_cnt_d;
      vsync_prev_q <= vsync_prev_d;
    end
  end

  assign level_o = level_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/palette_lookup.sv
// Pixel index -> palette RAM -> RGB444 with sideband aligned to the RAM read latency.
// Brightness fading is built only when PALETTE_LOOKUP_FADE_EN is defined.
module palette_lookup
  import palette_pkg::*;
#(
  parameter int RD_LATENCY       = 1,
  parameter int FADE_STEP_FRAMES = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    pix_valid_i,
  input  logic [7:0]              pix_idx_i,
  input  logic                    border_i,
  input  logic [7:0]              border_idx_i,
  input  logic                    hsync_i,
  input  logic                    vsync_i,
  input  logic                    blank_i,
  output logic                    pal_rd_en_o,
  output logic [7:0]              pal_rd_addr_o,
  input  logic [15:0]             pal_rd_data_i,
  output logic [RGB_W-1:0]        rgb_o,
  output logic                    rgb_valid_o,
  output logic                    hsync_o,
  output logic                    vsync_o,
  output logic                    blank_o,
  input  logic                    fade_start_i,
  input  logic                    fade_dir_i,
  output logic                    fade_busy_o,
  output logic [FADE_LEVEL_W-1:0] fade_level_o
);

  logic [FADE_LEVEL_W-1:0] fade_level;
  logic                    fade_busy;
  logic                    unused_bits;

`ifdef PALETTE_LOOKUP_FADE_EN
  palette_fade_ctrl #(
    .STEP_FRAMES (FADE_STEP_FRAMES)
  ) u_fade_ctrl (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .vsync_i (vsync_i),
    .start_i (fade_start_i),
    .dir_i   (fade_dir_i),
    .level_o (fade_level),
    .busy_o  (fade_busy)
  );
  assign unused_bits = ^pal_rd_data_i[15:12];
`else
  localparam int unused_step_frames = FADE_STEP_FRAMES;
  assign fade_level  = FADE_LEVEL_MAX;
  assign fade_busy   = 1'b0;
  assign unused_bits = ^{pal_rd_data_i[15:12], fade_start_i, fade_dir_i};
`endif

  assign pal_rd_addr_o = border_i ? border_idx_i : pix_idx_i;
  assign pal_rd_en_o   = pix_valid_i;

  // Stage RD_LATENCY-1 of the delay line lines up with the RAM read data.
  sideband_t        sb_q [RD_LATENCY];
  sideband_t        sb_d [RD_LATENCY];
  sideband_t        sb_ram;
  sideband_t        out_sb_q, out_sb_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic [RGB_W-1:0] rgb_scaled;
  logic [COMP_W-1:0] comp_r, comp_g, comp_b;

  assign sb_ram = sb_q[RD_LATENCY-1];

  always_comb begin
    sb_d[0] = '{valid: pix_valid_i, hsync: hsync_i, vsync: vsync_i, blank: blank_i};
    for (int i = 1; i < RD_LATENCY; i++) begin
      sb_d[i] = sb_q[i-1];
    end
  end

  always_comb begin
    comp_r = pal_rd_data_i[R_LSB +: COMP_W];
    comp_g = pal_rd_data_i[G_LSB +: COMP_W];
    comp_b = pal_rd_data_i[B_LSB +: COMP_W];
`ifdef PALETTE_LOOKUP_FADE_EN
    rgb_scaled = {scale_comp(comp_r, fade_level),
                  scale_comp(comp_g, fade_level),
                  scale_comp(comp_b, fade_level)};
`else
    rgb_scaled = {comp_r, comp_g, comp_b};
`endif
    rgb_d    = (sb_ram.valid && !sb_ram.blank) ? rgb_scaled : '0;
    out_sb_d = sb_ram;
  end

  // NOTE: the sideband delay line is reset (it is only a few flops) so outputs are blanked
  // and invalid until real pixels arrive; the palette RAM contents themselves are never reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        sb_q[i] <= SIDEBAND_RESET;
      end
      out_sb_q <= SIDEBAND_RESET;
      rgb_q    <= '0;
    end else begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        sb_q[i] <= sb_d[i];
      end
      out_sb_q <= out_sb_d;
      rgb_q    <= rgb_d;
    end
  end

  assign rgb_o        = rgb_q;
  assign rgb_valid_o  = out_sb_q.valid;
  assign hsync_o      = out_sb_q.hsync;
  assign vsync_o      = out_sb_q.vsync;
  assign blank_o      = out_sb_q.blank;
  assign fade_busy_o  = fade_busy;
  assign fade_level_o = fade_level;

endmodule
